// File: rtl/loop_mon_pkg.sv
// Shared types and constants for the loop transaction recorder.
package loop_mon_pkg;

  localparam int TXN_W = 16;  // transaction id width
  localparam int DROP_W = 16; // drop counter width
  localparam int ERR_W = 3;

  // Sticky error flag bit positions
  localparam int ERR_QOVF   = 0; // start seen while the start queue was full
  localparam int ERR_ORPHAN = 1; // done seen with no outstanding start
  localparam int ERR_DROP   = 2; // record lost to a full output FIFO

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  // Record layout at the default widths (CW=32, LW=24, IW=16).
  // The recorder builds the same field order for any parameter set.
  typedef struct packed {
    logic [TXN_W-1:0] txn_id;
    logic [31:0]      start_ts;
    logic [23:0]      latency;
    logic [15:0]      iters;
    logic [15:0]      stalls;
  } rec_t;

  function automatic int rec_width(input int cw, input int lw, input int iw);
    return TXN_W + cw + lw + 2 * iw;
  endfunction

endpackage

// File: rtl/loop_txn_recorder_if.sv
// Tap and record-stream bundle between an HLS top, the recorder and the dump stage.
// Record stream: a record moves on every clock edge where rec_valid and rec_ready
// are both high; while rec_valid is high and rec_ready low, rec_data does not change.
interface loop_txn_recorder_if
  import loop_mon_pkg::*;
#(
  parameter int CW = 32,
  parameter int LW = 24,
  parameter int IW = 16
);

  localparam int REC_W = rec_width(CW, LW, IW);

  logic              ap_start;
  logic              ap_ready;
  logic              ap_done;
  logic              ap_continue;
  logic              iter_start_en;
  logic              iter_start_blk;
  logic              iter_end_en;
  logic              iter_end_blk;
  logic              finish;
  logic              rec_valid;
  logic              rec_ready;
  logic [REC_W-1:0]  rec_data;
  logic [DROP_W-1:0] drop_cnt;
  logic [ERR_W-1:0]  err_flags;
  logic              flush_done;
  fsm_e              state;

  // Recorder side
  modport master (
    input  ap_start, ap_ready, ap_done, ap_continue,
    input  iter_start_en, iter_start_blk, iter_end_en, iter_end_blk,
    input  finish, rec_ready,
    output rec_valid, rec_data, drop_cnt, err_flags, flush_done, state
  );

  // Environment side: taps, run control and record consumer
  modport slave (
    output ap_start, ap_ready, ap_done, ap_continue,
    output iter_start_en, iter_start_blk, iter_end_en, iter_end_blk,
    output finish, rec_ready,
    input  rec_valid, rec_data, drop_cnt, err_flags, flush_done, state
  );

endinterface

// File: rtl/mon_sync_fifo.sv
// Synchronous FIFO with full/empty flags; a push into a full FIFO is accepted
// when a pop happens in the same cycle. DEPTH must be a power of 2.
module mon_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are qualified by count, so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/loop_txn_recorder.sv
// Records one {id, start, latency, iterations, stalls} entry per completed
// ap_ctrl transaction of a pipelined HLS top and streams them to the dumper.
module loop_txn_recorder
  import loop_mon_pkg::*;
#(
  parameter int CW         = 32,
  parameter int LW         = 24,
  parameter int IW         = 16,
  parameter int MAX_OUT    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  loop_txn_recorder_if.master bus
);

  localparam int QW = TXN_W + CW;
  localparam int RW = rec_width(CW, LW, IW);
  localparam int DW = (CW > LW) ? CW : LW;
  localparam logic [DW-1:0] LAT_MAX = DW'({LW{1'b1}});
  localparam logic [IW-1:0] CNT_MAX = {IW{1'b1}};

  typedef struct packed {
    logic [TXN_W-1:0] txn_id;
    logic [CW-1:0]    start_ts;
    logic [LW-1:0]    latency;
    logic [IW-1:0]    iters;
    logic [IW-1:0]    stalls;
  } txn_rec_t;

  fsm_e              state;
  fsm_e              state_nx;
  logic [CW-1:0]     cyc;
  logic [TXN_W-1:0]  txn_id;
  logic [IW-1:0]     iters_q;
  logic [IW-1:0]     stalls_q;
  logic [IW-1:0]     iters_nx;
  logic [IW-1:0]     stalls_nx;
  logic [DROP_W-1:0] drop_q;
  logic [ERR_W-1:0]  err_q;
  logic [ERR_W-1:0]  err_set;
  logic              run;
  logic              ev_s;
  logic              ev_d;
  logic              ev_ie;
  logic              ev_st;
  logic              q_push;
  logic              q_pop;
  logic              q_full;
  logic              q_empty;
  logic [QW-1:0]     q_din;
  logic [QW-1:0]     q_dout;
  logic [TXN_W-1:0]  q_id;
  logic [CW-1:0]     q_ts;
  logic [CW-1:0]     lat_raw;
  logic [DW-1:0]     lat_ext;
  logic [LW-1:0]     lat_sat;
  txn_rec_t          rec_new;
  logic              r_push;
  logic              r_pop;
  logic              r_full;
  logic              r_empty;
  logic              drop;
  logic              rec_valid;
  logic [RW-1:0]     r_dout;

  // Events only count while running; flushing and done ignore the taps
  assign run   = (state == RUN);
  assign ev_s  = run & bus.ap_start & bus.ap_ready;
  assign ev_d  = run & bus.ap_done & bus.ap_continue;
  assign ev_ie = run & bus.iter_end_en & ~bus.iter_end_blk;
  assign ev_st = run & bus.iter_start_en & bus.iter_start_blk;

  // Done retires the oldest start first, so start+done on a full queue fits
  assign q_pop  = ev_d & ~q_empty;
  assign q_push = ev_s & (~q_full | q_pop);
  assign q_din  = {txn_id, cyc};
  assign {q_id, q_ts} = q_dout;

  mon_sync_fifo #(.WIDTH(QW), .DEPTH(MAX_OUT)) u_start_q (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  // Modular latency, clamped to the latency field
  assign lat_raw = cyc - q_ts;
  assign lat_ext = DW'(lat_raw);
  assign lat_sat = (lat_ext > LAT_MAX) ? LAT_MAX[LW-1:0] : lat_ext[LW-1:0];

  // Counts as of the end of this cycle; the record includes the done cycle
  assign iters_nx  = (ev_ie && iters_q != CNT_MAX) ? iters_q + 1'b1 : iters_q;
  assign stalls_nx = (ev_st && stalls_q != CNT_MAX) ? stalls_q + 1'b1 : stalls_q;

  assign rec_new = '{txn_id: q_id, start_ts: q_ts, latency: lat_sat,
                     iters: iters_nx, stalls: stalls_nx};

  assign r_push    = q_pop;
  assign rec_valid = ~r_empty & (state != DONE);
  assign r_pop     = rec_valid & bus.rec_ready;
  assign drop      = r_push & r_full & ~r_pop;

  mon_sync_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_rec_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (r_push),
    .din   (rec_new),
    .pop   (r_pop),
    .dout  (r_dout),
    .full  (r_full),
    .empty (r_empty)
  );

  // Collect the sticky error conditions raised this cycle
  always_comb begin
    err_set             = '0;
    err_set[ERR_QOVF]   = ev_s & q_full & ~q_pop;
    err_set[ERR_ORPHAN] = ev_d & q_empty;
    err_set[ERR_DROP]   = drop;
  end

  // Timestamp, id, per-transaction counters, error and drop bookkeeping
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cyc      <= '0;
      txn_id   <= '0;
      iters_q  <= '0;
      stalls_q <= '0;
      err_q    <= '0;
      drop_q   <= '0;
    end else begin
      cyc      <= cyc + 1'b1;
      if (q_push) txn_id <= txn_id + 1'b1;
      iters_q  <= ev_d ? '0 : iters_nx;
      stalls_q <= ev_d ? '0 : stalls_nx;
      err_q    <= err_q | err_set;
      if (drop && drop_q != {DROP_W{1'b1}}) drop_q <= drop_q + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state <= RUN;
    else           state <= state_nx;
  end

  // FSM next state; an already-drained FIFO skips straight to DONE
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:     if (bus.finish) state_nx = (r_empty && !r_push) ? DONE : FLUSH;
      FLUSH:   if (r_empty) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = RUN;
    endcase
  end

  assign bus.rec_valid  = rec_valid;
  assign bus.rec_data   = rec_valid ? r_dout : '0;
  assign bus.drop_cnt   = drop_q;
  assign bus.err_flags  = err_q;
  assign bus.flush_done = (state == DONE);
  assign bus.state      = state;

endmodule

// File: tb/tb_loop_txn_recorder.sv
// Directed bench for loop_txn_recorder with an 8-bit timestamp so wrap is reachable.
module tb_loop_txn_recorder;

  localparam int CW = 8;
  localparam int LW = 24;
  localparam int IW = 16;
  localparam int RW = 80;
  localparam int T1 = 15;
  localparam int T2 = 14;
  localparam int TN = T1 + T2;

  typedef struct packed {
    logic [15:0] txn_id;
    logic [7:0]  start_ts;
    logic [23:0] latency;
    logic [15:0] iters;
    logic [15:0] stalls;
  } rec_t;

  typedef struct packed {
    logic       s;
    logic       d;
    logic       ie;
    logic       st;
    logic       rdy;
    logic       ev;
    logic [2:0] err;
    rec_t       r;
  } vec_t;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;
  int            done_cyc;
  vec_t          tab [TN];
  logic [RW-1:0] exp_q [$];

  loop_txn_recorder_if #(.CW(CW), .LW(LW), .IW(IW)) bus ();

  loop_txn_recorder #(
    .CW(CW), .LW(LW), .IW(IW), .MAX_OUT(4), .FIFO_DEPTH(16)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  // Clock and reset
  always #5 ap_clk = ~ap_clk;

  task automatic step();
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  task automatic idle(input logic rdy);
    bus.ap_start       = 1'b0;
    bus.ap_ready       = 1'b0;
    bus.ap_done        = 1'b0;
    bus.ap_continue    = 1'b1;
    bus.iter_start_en  = 1'b0;
    bus.iter_start_blk = 1'b0;
    bus.iter_end_en    = 1'b0;
    bus.iter_end_blk   = 1'b0;
    bus.finish         = 1'b0;
    bus.rec_ready      = rdy;
  endtask

  // Leaves the bench at the negedge of cycle 0 (cyc == 0)
  task automatic do_reset();
    idle(1'b1);
    ap_rst_n = 1'b0;
    step();
    ap_rst_n = 1'b1;
  endtask

  task automatic ev_start();
    bus.ap_start = 1'b1;
    bus.ap_ready = 1'b1;
  endtask

  function automatic rec_t mk(input int id, input int ts, input int lat,
                              input int it, input int st);
    rec_t r;
    r.txn_id   = id[15:0];
    r.start_ts = ts[7:0];
    r.latency  = lat[23:0];
    r.iters    = it[15:0];
    r.stalls   = st[15:0];
    return r;
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic ev, input logic [RW-1:0] er);
    chk(name, {bus.rec_valid, (ev ? bus.rec_data : {RW{1'b0}})}, {ev, (ev ? er : {RW{1'b0}})});
  endtask

  task automatic chk_rst(input string name);
    chk(name, {bus.rec_valid, bus.rec_data, bus.drop_cnt, bus.err_flags, bus.flush_done}, '0);
  endtask

  initial begin
    // Vector table: segment 1 = single transaction, segment 2 = overlap
    for (int i = 0; i < TN; i++) begin
      tab[i]     = '0;
      tab[i].rdy = 1'b1;
    end
    tab[5].s   = 1'b1;
    tab[7].ie  = 1'b1;
    tab[8].ie  = 1'b1;
    tab[9].ie  = 1'b1;
    tab[12].d  = 1'b1;
    tab[13].ev = 1'b1;
    tab[13].r  = mk(0, 5, 7, 3, 0);
    for (int k = 0; k < 3; k++) begin
      tab[T1 + 2 + k].s   = 1'b1;
      tab[T1 + 9 + k].d   = 1'b1;
      tab[T1 + 10 + k].ev = 1'b1;
      tab[T1 + 10 + k].r  = mk(k, 2 + k, 7, 0, 0);
    end

    for (int i = 0; i < TN; i++) begin
      if (i == 0 || i == T1) begin
        do_reset();
        chk_rst("reset_state");
      end
      chk($sformatf("vec%0d", i),
          {bus.rec_valid, bus.err_flags, (tab[i].ev ? bus.rec_data : {RW{1'b0}})},
          {tab[i].ev, tab[i].err, (tab[i].ev ? tab[i].r : {RW{1'b0}})});
      idle(tab[i].rdy);
      if (tab[i].s) ev_start();
      bus.ap_done        = tab[i].d;
      bus.iter_end_en    = tab[i].ie;
      bus.iter_start_en  = tab[i].st;
      bus.iter_start_blk = tab[i].st;
      step();
    end

    // Start-queue overflow, in-order retirement, orphan done
    do_reset();
    chk_rst("ovf_reset");
    for (int c = 0; c < 5; c++) begin
      idle(1'b1);
      ev_start();
      step();
    end
    chk("ovf_flag", bus.err_flags, 3'b001);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      bus.ap_done = 1'b1;
      step();
      chk_out($sformatf("ovf_rec%0d", k), 1'b1, mk(k, k, 5, 0, 0));
    end
    idle(1'b1);
    bus.ap_done = 1'b1;
    step();
    chk("orphan_flag", {bus.rec_valid, bus.err_flags}, {1'b0, 3'b011});
    idle(1'b1);
    ev_start();
    step();
    idle(1'b1);
    bus.ap_done = 1'b1;
    step();
    chk_out("id_after_ovf", 1'b1, mk(4, 10, 1, 0, 0));

    // Back-pressure: 17 completions into a 16-deep FIFO
    do_reset();
    chk_rst("bp_reset");
    for (int j = 0; j < 17; j++) begin
      chk_out("bp_hold_s", j > 0, mk(0, 0, 1, 0, 0));
      idle(1'b0);
      ev_start();
      step();
      chk_out("bp_hold_d", j > 0, mk(0, 0, 1, 0, 0));
      idle(1'b0);
      bus.ap_done = 1'b1;
      step();
    end
    chk("bp_drop", {bus.drop_cnt, bus.err_flags}, {16'd1, 3'b100});
    for (int k = 0; k < 16; k++) begin
      chk_out($sformatf("bp_drain%0d", k), 1'b1, mk(k, 2 * k, 1, 0, 0));
      idle(1'b1);
      step();
    end
    chk_out("bp_empty", 1'b0, '0);

    // Timestamp wrap, stall/iteration qualification, counter restart
    do_reset();
    chk_rst("wrap_reset");
    idle(1'b1);
    for (int c = 0; c < 250; c++) step();
    idle(1'b1); ev_start(); step();                                        // 250
    idle(1'b1); bus.ap_start = 1'b1;
    bus.iter_end_en = 1'b1; bus.iter_end_blk = 1'b1; step();               // 251
    for (int c = 0; c < 4; c++) begin                                      // 252..255
      idle(1'b1); bus.iter_start_en = 1'b1; bus.iter_start_blk = 1'b1; step();
    end
    idle(1'b1); bus.iter_start_en = 1'b1; step();                          // 0
    idle(1'b1); step();                                                    // 1
    idle(1'b1); bus.iter_end_en = 1'b1; step();                            // 2
    idle(1'b1); bus.ap_done = 1'b1; bus.ap_continue = 1'b0; step();        // 3
    idle(1'b1); bus.ap_done = 1'b1; bus.iter_end_en = 1'b1; step();        // 4
    chk_out("wrap_rec", 1'b1, mk(0, 250, 10, 2, 4));
    idle(1'b1); ev_start(); step();                                        // 5
    idle(1'b1); step();                                                    // 6
    idle(1'b1); bus.ap_done = 1'b1; step();                                // 7
    chk_out("restart_rec", 1'b1, mk(1, 5, 2, 0, 0));
    chk("wrap_err", bus.err_flags, 3'b000);

    // Flush with toggling ready; taps ignored while flushing
    do_reset();
    chk_rst("flush_reset");
    for (int j = 0; j < 3; j++) begin
      idle(1'b0); ev_start(); step();
      idle(1'b0); bus.ap_done = 1'b1; step();
      exp_q.push_back(mk(j, 2 * j, 1, 0, 0));
    end
    done_cyc = -1;
    for (int c = 6; c < 40; c++) begin
      idle(c % 2 == 1);
      if (c == 6) bus.finish = 1'b1;
      if (c == 7) ev_start();
      if (c == 8) bus.ap_done = 1'b1;
      if (bus.flush_done) begin
        done_cyc = c;
        break;
      end
      if (bus.rec_valid && bus.rec_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL flush_extra: got record %0h expected none", bus.rec_data);
        end else begin
          chk("flush_rec", bus.rec_data, exp_q.pop_front());
        end
      end
      step();
    end
    chk("flush_done_cycle", done_cyc, 13);
    chk("flush_all_delivered", exp_q.size(), 0);
    chk("flush_err", {bus.err_flags, bus.drop_cnt}, '0);
    idle(1'b1); ev_start(); step();
    idle(1'b1); bus.ap_done = 1'b1; step();
    chk("done_hold", {bus.rec_valid, bus.flush_done}, 2'b01);

    // Reset in the middle of a flush, then finish with an empty FIFO
    do_reset();
    for (int j = 0; j < 2; j++) begin
      idle(1'b0); ev_start(); step();
      idle(1'b0); bus.ap_done = 1'b1; step();
    end
    idle(1'b0); bus.finish = 1'b1; step();
    idle(1'b0); step();
    chk("midflush_pre", {bus.rec_valid, bus.flush_done}, 2'b10);
    idle(1'b0);
    ap_rst_n = 1'b0;
    step();
    ap_rst_n = 1'b1;
    chk("midflush_rst", {bus.rec_valid, bus.flush_done}, 2'b00);
    idle(1'b1); bus.finish = 1'b1; step();
    chk("empty_finish", {bus.rec_valid, bus.flush_done}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
